multi_button_conditioner: RTL

//   N-channel push-button conditioner for the candle controller front panel. Each channel
//   has a 2-FF synchroniser, symmetric press/release debounce, a debounced level, and

---
 rtl/multi_button_conditioner_if.sv | 38 +++
 rtl/multi_button_conditioner.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multi_button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_button_conditioner_if
// Description : Button bundle between the front-panel pins and the
//               conditioner: raw inputs in, debounced level and strobes out.
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_button_conditioner_if #(
  parameter int NUM_BTN = 4
);
  logic [NUM_BTN-1:0] btn;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] press_pulse;
  logic [NUM_BTN-1:0] release_pulse;
  logic [NUM_BTN-1:0] long_pulse;
  logic [NUM_BTN-1:0] repeat_pulse;

  // Board / consumer side: drives raw buttons, observes conditioned outputs
  modport master (
    output btn,
    input  level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  repeat_pulse
  );

  // Conditioner side
  modport slave (
    input  btn,
    output level,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output repeat_pulse
  );
endinterface
`default_nettype wire

// File: rtl/multi_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : multi_button_conditioner
// Description : N-channel push-button conditioner. Each channel has a 2-FF
//               synchroniser, symmetric press/release debounce, a debounced
//               level and one-cycle press/release/long/repeat strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_button_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 50,
  parameter int LONG_CYCLES     = 0,
  parameter int REPEAT_CYCLES   = 0,
  parameter int CNT_W           = 32,
  parameter int ACTIVE_LOW      = 0
) (
  input  wire logic                  clk_50MHz,
  input  wire logic                  rst,
  multi_button_conditioner_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DEB_PRESS   = 3'd1,
    ST_HELD        = 3'd2,
    ST_LONG        = 3'd3,
    ST_DEB_RELEASE = 3'd4
  } state_t;

  // Terminal counts are stored as "last" values so every timer test is an
  // equality against a constant; disabled timers never get compared.
  localparam logic [CNT_W-1:0] c_deb_last  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_long_last = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_rep_last  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
  localparam logic             c_long_en   = (LONG_CYCLES != 0);
  localparam logic             c_rep_en    = (REPEAT_CYCLES != 0) && (LONG_CYCLES != 0);
  localparam logic [NUM_BTN-1:0] c_invert  = (ACTIVE_LOW != 0) ? {NUM_BTN{1'b1}} : '0;

  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [NUM_BTN-1:0] w_btn_s;

  // Two-stage synchroniser for all raw button inputs
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.btn;
      r_sync2 <= r_sync1;
    end
  end

  // Polarity normalisation so the FSM always sees 1 = pressed
  assign w_btn_s = r_sync2 ^ c_invert;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_long_flag;
    logic             w_long_flag_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             r_press;
    logic             w_press_nxt;
    logic             r_release;
    logic             w_release_nxt;
    logic             r_long;
    logic             w_long_nxt;
    logic             r_repeat;
    logic             w_repeat_nxt;

    // Saturating increment: a button held forever parks the timer, never wraps
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one;

    // Channel state, timer, long flag and registered outputs
    always_ff @(posedge clk_50MHz or posedge rst) begin
      if (rst) begin
        r_state     <= ST_IDLE;
        r_cnt       <= '0;
        r_long_flag <= 1'b0;
        r_level     <= 1'b0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
        r_long      <= 1'b0;
        r_repeat    <= 1'b0;
      end else begin
        r_state     <= w_state_nxt;
        r_cnt       <= w_cnt_nxt;
        r_long_flag <= w_long_flag_nxt;
        r_level     <= w_level_nxt;
        r_press     <= w_press_nxt;
        r_release   <= w_release_nxt;
        r_long      <= w_long_nxt;
        r_repeat    <= w_repeat_nxt;
      end
    end

    // Next-state, timer and strobe decode; strobes default low so each fires once
    always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = w_cnt_inc;
      w_long_flag_nxt = r_long_flag;
      w_level_nxt     = r_level;
      w_press_nxt     = 1'b0;
      w_release_nxt   = 1'b0;
      w_long_nxt      = 1'b0;
      w_repeat_nxt    = 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          w_cnt_nxt = '0;
          if (w_btn_s[i]) begin
            w_state_nxt = ST_DEB_PRESS;
            w_cnt_nxt   = c_cnt_one;
          end
        end
        ST_DEB_PRESS: begin
          if (!w_btn_s[i]) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == c_deb_last) begin
            w_state_nxt = ST_HELD;
            w_level_nxt = 1'b1;
            w_press_nxt = 1'b1;
            w_cnt_nxt   = '0;
          end
        end
        ST_HELD: begin
          if (!w_btn_s[i]) begin
            w_state_nxt = ST_DEB_RELEASE;
            w_cnt_nxt   = c_cnt_one;
          end else if (c_long_en && (r_cnt == c_long_last)) begin
            w_state_nxt     = ST_LONG;
            w_long_nxt      = 1'b1;
            w_long_flag_nxt = 1'b1;
            w_cnt_nxt       = '0;
          end
        end
        ST_LONG: begin
          if (!w_btn_s[i]) begin
            w_state_nxt = ST_DEB_RELEASE;
            w_cnt_nxt   = c_cnt_one;
          end else if (c_rep_en && (r_cnt == c_rep_last)) begin
            w_repeat_nxt = 1'b1;
            w_cnt_nxt    = '0;
          end
        end
        ST_DEB_RELEASE: begin
          if (w_btn_s[i]) begin
            // Release bounce: resume where we were, timers start over
            w_state_nxt = r_long_flag ? ST_LONG : ST_HELD;
            w_cnt_nxt   = '0;
          end else if (r_cnt == c_deb_last) begin
            w_state_nxt     = ST_IDLE;
            w_level_nxt     = 1'b0;
            w_release_nxt   = 1'b1;
            w_long_flag_nxt = 1'b0;
            w_cnt_nxt       = '0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    assign bus.level[i]         = r_level;
    assign bus.press_pulse[i]   = r_press;
    assign bus.release_pulse[i] = r_release;
    assign bus.long_pulse[i]    = r_long;
    assign bus.repeat_pulse[i]  = r_repeat;
  end : g_chan

endmodule
`default_nettype wire
